// File: rtl/chip_rst_seq_pkg.sv
// Shared definitions for the chip reset sequencer: FSM state encodings,
// stage index constants and a small elaboration helper.
package chip_rst_seq_pkg;

    localparam logic [1:0] ST_ASSERT = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_STAGE  = 2'd2;
    localparam logic [1:0] ST_READY  = 2'd3;

    localparam int STG_KEYEXP = 0;
    localparam int STG_CORE   = 1;
    localparam int STG_IO     = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_gap_cnt.sv
// Loadable up-counter with terminal-count compare, shared by the HOLD and
// STAGE phases of the reset sequencer.
module rst_gap_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tc = (cnt_reg == limit);

endmodule

// File: rtl/chip_rst_seq.sv
// Chip-side reset sequencer: holds all sub-blocks in reset while requested,
// then releases per-stage resets in order and signals ready/done.
module chip_rst_seq
    import chip_rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2,
    parameter int NUM_STAGES  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  busy,
    output logic                  ready,
    output logic                  done
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IW = $clog2(NUM_STAGES + 1);

    logic [1:0]            state_reg, state_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [NUM_STAGES-1:0] stage_rst_n_reg, stage_rst_n_next;
    logic                  ready_reg, ready_next;
    logic                  done_reg, done_next;
    logic                  armed_reg;

    logic                  cnt_clr;
    logic                  cnt_en;
    logic [CW-1:0]         cnt_limit;
    logic                  cnt_tc;
    logic                  rel_en;
    logic [NUM_STAGES-1:0] rel_vec;

    rst_gap_cnt #(
        .W(CW)
    ) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .tc    (cnt_tc)
    );

    // One-hot release decode of the current stage index.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_rel
            assign rel_vec[gi] = rel_en && (idx_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ready_next = ready_reg;
        done_next  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        cnt_limit  = CW'(HOLD_CYCLES - 1);
        rel_en     = 1'b0;

        if (rst_req) begin
            state_next = ST_ASSERT;
            idx_next   = IW'(STG_KEYEXP);
            ready_next = 1'b0;
            cnt_clr    = 1'b1;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    state_next = ST_HOLD;
                    cnt_clr    = 1'b1;
                end
                ST_HOLD: begin
                    // The first edge after rst release plays the role of the
                    // ASSERT->HOLD edge, so it must not advance the count.
                    if (armed_reg) begin
                        if (cnt_tc) begin
                            rel_en  = 1'b1;
                            cnt_clr = 1'b1;
                            if (NUM_STAGES == 1) begin
                                state_next = ST_READY;
                            end else begin
                                state_next = ST_STAGE;
                                idx_next   = IW'(STG_CORE);
                            end
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                ST_STAGE: begin
                    cnt_limit = CW'(STAGE_GAP - 1);
                    if (cnt_tc) begin
                        rel_en   = 1'b1;
                        cnt_clr  = 1'b1;
                        idx_next = idx_reg + 1'b1;
                        if (idx_reg == IW'(NUM_STAGES - 1)) begin
                            state_next = ST_READY;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_READY: begin
                    cnt_clr = 1'b1;
                    if (!ready_reg) begin
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_ASSERT;
                end
            endcase
        end

        stage_rst_n_next = rst_req ? '0 : (stage_rst_n_reg | rel_vec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_HOLD;
            idx_reg         <= '0;
            stage_rst_n_reg <= '0;
            ready_reg       <= 1'b0;
            done_reg        <= 1'b0;
            armed_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            stage_rst_n_reg <= stage_rst_n_next;
            ready_reg       <= ready_next;
            done_reg        <= done_next;
            armed_reg       <= 1'b1;
        end
    end

    assign stage_rst_n = stage_rst_n_reg;
    assign busy        = ~&stage_rst_n_reg;
    assign ready       = ready_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_chip_rst_seq.sv
// Self-checking bench for chip_rst_seq: default-parameter instance plus a
// HOLD=1/GAP=1/STAGES=1 corner instance driven by the same stimulus.
module tb_chip_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_req;
    logic [2:0] stage_rst_n;
    logic       busy, ready, done;
    logic [0:0] c_stage_rst_n;
    logic       c_busy, c_ready, c_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chip_rst_seq #(
        .HOLD_CYCLES(4),
        .STAGE_GAP  (2),
        .NUM_STAGES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_req     (rst_req),
        .stage_rst_n (stage_rst_n),
        .busy        (busy),
        .ready       (ready),
        .done        (done)
    );

    chip_rst_seq #(
        .HOLD_CYCLES(1),
        .STAGE_GAP  (1),
        .NUM_STAGES (1)
    ) dut_c (
        .clk         (clk),
        .rst         (rst),
        .rst_req     (rst_req),
        .stage_rst_n (c_stage_rst_n),
        .busy        (c_busy),
        .ready       (c_ready),
        .done        (c_done)
    );

    typedef struct {
        logic       req;
        logic [2:0] stg;
        logic       rdy;
        logic       dn;
        logic       c_stg;
        logic       c_rdy;
        logic       c_dn;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic req, input logic [2:0] stg, input logic rdy,
                                input logic dn, input logic cs, input logic cr, input logic cd);
        vec_t v;
        v.req = req; v.stg = stg; v.rdy = rdy; v.dn = dn;
        v.c_stg = cs; v.c_rdy = cr; v.c_dn = cd;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input vec_t v);
        cmp({nm, ".stage"},   stage_rst_n, v.stg);
        cmp({nm, ".busy"},    {2'b00, busy}, {2'b00, ~&v.stg});
        cmp({nm, ".ready"},   {2'b00, ready}, {2'b00, v.rdy});
        cmp({nm, ".done"},    {2'b00, done}, {2'b00, v.dn});
        cmp({nm, ".c_stage"}, {2'b00, c_stage_rst_n}, {2'b00, v.c_stg});
        cmp({nm, ".c_busy"},  {2'b00, c_busy}, {2'b00, ~v.c_stg});
        cmp({nm, ".c_ready"}, {2'b00, c_ready}, {2'b00, v.c_rdy});
        cmp({nm, ".c_done"},  {2'b00, c_done}, {2'b00, v.c_dn});
        $display("%s: stage=%b busy=%b ready=%b done=%b | corner stage=%b ready=%b done=%b",
                 nm, stage_rst_n, busy, ready, done, c_stage_rst_n, c_ready, c_done);
    endtask

    // Expected outputs k edges after the sequence reference edge; k<0 = held in reset.
    function automatic vec_t model(input int k);
        vec_t v;
        v = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (k >= 0) begin
            for (int i = 0; i < 3; i++) begin
                if (k >= 4 + 2 * i) v.stg[i] = 1'b1;
            end
            v.rdy   = (k >= 9);
            v.dn    = (k == 9);
            v.c_stg = (k >= 1);
            v.c_rdy = (k >= 2);
            v.c_dn  = (k == 2);
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string nm, input int k_last);
        for (int k = 0; k <= k_last; k++) begin
            tick();
            check_all($sformatf("%s_e%0d", nm, k), model(k));
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[3]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 11; i < 16; i++) vecs[i] = mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) vecs[16 + i] = vecs[i];

        rst     = 1'b1;
        rst_req = 1'b0;
        #1;
        check_all("reset_state", mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Power-on sequence, then a 5-cycle request from READY and its replay.
        for (int i = 0; i < 27; i++) begin
            rst_req = vecs[i].req;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end
        rst_req = 1'b0;

        // Mid-sequence abort when stage_rst_n == 011.
        rst_req = 1'b1; tick(); check_all("s3_req", model(-1));
        rst_req = 1'b0;
        run_seq("s3_pre", 6);
        rst_req = 1'b1; tick(); check_all("s3_abort", model(-1));
        rst_req = 1'b0;
        run_seq("s3_restart", 10);

        // Request collides with the stage 2 release edge.
        rst_req = 1'b1; tick(); check_all("s4_req", model(-1));
        rst_req = 1'b0;
        run_seq("s4_pre", 7);
        rst_req = 1'b1; tick(); check_all("s4_coll_rel", model(-1));
        rst_req = 1'b0;
        // Request collides with the done edge.
        run_seq("s4b_pre", 8);
        rst_req = 1'b1; tick(); check_all("s4_coll_done", model(-1));
        rst_req = 1'b0;
        run_seq("s4_restart", 10);

        // Asynchronous reset between edges while READY.
        #3;
        rst = 1'b1;
        #1;
        check_all("s5_async", model(-1));
        rst = 1'b0;
        run_seq("s5_replay", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
